// File: rtl/data_mem_responder.sv
// data_mem_responder: single-ported word memory behind a valid/ready request
// channel with a fixed, parameterizable response latency.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_we              1 = store, 0 = load
//   req_addr            byte address (word-aligned, < 4*DEPTH_WORDS to be legal)
//   req_wdata, req_be   store data and per-byte enables
//   resp_valid/resp_ready response handshake
//   resp_rdata          load data (0 for stores and errors)
//   resp_err            misaligned or out-of-range access
//
// A request is accepted in IDLE, sits in WAIT for WAIT_CYCLES cycles, and the
// memory is touched on the edge that enters RESP. The response is then held
// until resp_ready. Memory contents survive reset.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LD  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With WAIT_CYCLES == 0 the accept edge is also the commit edge, so the
  // live request inputs are used; otherwise the latched copy is.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  logic        cur_err;
  logic [AW-1:0] cur_idx;
  logic        enter_resp, commit;
  logic [31:0] rd_word;

  always_comb begin
    cur_we    = (state_q == IDLE) ? req_we    : we_q;
    cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    cur_be    = (state_q == IDLE) ? req_be    : be_q;
    cur_err   = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH32);
    cur_idx   = cur_addr[AW+1:2];
    rd_word   = mem[cur_idx];
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  // next state / countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = CNT_LD;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  // rst gate keeps the un-reset memory quiet while reset is held
  assign commit     = enter_resp && rst && cur_we && !cur_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        resp_rdata <= (cur_we || cur_err) ? 32'd0 : rd_word;
        resp_err   <= cur_err;
      end
    end
  end

  // storage: no reset, byte-masked write on the commit edge
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++)
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=2/DEPTH=256 and
// WAIT_CYCLES=0/DEPTH=16) driven by randomized and directed transactions.
// A transaction-level model predicts req_ready/resp_valid/resp_rdata/resp_err
// every cycle; directed literals pin the model.
module tb_data_mem_responder;
  localparam int D0 = 256, W0 = 2;
  localparam int D1 = 16,  W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], req_valid[2], req_ready[2], req_we[2];
  logic        resp_valid[2], resp_ready[2], resp_err[2];
  logic [31:0] req_addr[2], req_wdata[2], resp_rdata[2];
  logic [3:0]  req_be[2];

  data_mem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wc(input int d);  return (d == 0) ? W0 : W1; endfunction
  function automatic int dep(input int d); return (d == 0) ? D0 : D1; endfunction
  function automatic logic [31:0] pre(input int i); return 32'hC0DE0000 | 32'(i); endfunction

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          pend[2];
  int          due[2];
  int          acc_cnt[2];
  bit          t_we[2];
  logic [31:0] t_a[2], t_wd[2];
  logic [3:0]  t_be[2];
  logic [31:0] e_rd[2];
  logic        e_err[2];
  logic [31:0] mm[2][256];

  // memory effect and response of the pending transaction
  task automatic commit(input int d);
    int  i;
    bit  err;
    i   = int'(t_a[d][31:2]);
    err = (t_a[d][1:0] != 2'b00) || (i >= dep(d));
    e_err[d] = err;
    e_rd[d]  = 32'd0;
    if (!err) begin
      if (t_we[d]) begin
        for (int b = 0; b < 4; b++)
          if (t_be[d][b]) mm[d][i][8*b +: 8] = t_wd[d][8*b +: 8];
      end else e_rd[d] = mm[d][i];
    end
  endtask

  // A response is visible from the cycle whose index reaches accept+WAIT;
  // the memory effect happens on that same edge.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) pend[d] = 1'b0;
      else begin
        if (pend[d]) begin
          if (cyc - 1 >= due[d] && resp_ready[d]) pend[d] = 1'b0;
        end else if (req_valid[d]) begin
          pend[d] = 1'b1;
          due[d]  = cyc + wc(d);
          t_we[d] = req_we[d]; t_a[d] = req_addr[d];
          t_wd[d] = req_wdata[d]; t_be[d] = req_be[d];
          acc_cnt[d]++;
        end
        if (pend[d] && cyc == due[d]) commit(d);
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
        chk($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 32'd0);
        chk($sformatf("rst_resp_rdata%0d", d), resp_rdata[d], 32'd0);
        chk($sformatf("rst_resp_err%0d", d), 32'(resp_err[d]), 32'd0);
      end else begin
        bit ev;
        ev = pend[d] && (cyc >= due[d]);
        chk($sformatf("req_ready%0d", d), 32'(req_ready[d]), 32'(!pend[d]));
        chk($sformatf("resp_valid%0d", d), 32'(resp_valid[d]), 32'(ev));
        if (ev) begin
          chk($sformatf("resp_rdata%0d", d), resp_rdata[d], e_rd[d]);
          chk($sformatf("resp_err%0d", d), 32'(resp_err[d]), 32'(e_err[d]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input int d, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    bit ok;
    int n;
    n = 0;
    req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    req_valid[d] = 1'b1;
    do begin
      @(negedge clk); ok = req_ready[d];
      @(posedge clk); n++;
    end while (!ok && n < 64);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout%0d: got no accept expected accept within 64 cycles", d);
    end
    #1;
    req_valid[d] = 1'b0;
    // junk on the request bus after accept must be ignored
    req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
  endtask

  task automatic await_resp(input int d, output int lat, output logic [31:0] rd, output logic er);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid[d] && lat < 64);
    if (!resp_valid[d]) begin
      checks++; errors++;
      $display("FAIL resp_timeout%0d: got no resp_valid expected within 64 cycles", d);
    end
    rd = resp_rdata[d];
    er = resp_err[d];
  endtask

  task automatic finish_resp(input int d, input int hold);
    repeat (hold) @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    issue(d, we, a, wd, be);
    await_resp(d, lat, rd, er);
    finish_resp(d, hold);
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 32'($urandom_range(0, dep(d) - 1) * 4 + $urandom_range(1, 3));
      1: return 32'((dep(d) + $urandom_range(0, 15)) * 4);
      2: return $urandom;
      default: return 32'($urandom_range(0, dep(d) - 1) * 4);
    endcase
  endfunction

  task automatic rand_phase(input int d, input int n, input int maxhold);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [3:0]  be;
    for (int k = 0; k < n; k++) begin
      be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      txn(d, 1'($urandom), rand_addr(d), $urandom, be, $urandom_range(0, maxhold), rd, er, lat);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_be[d] = 4'd0; resp_ready[d] = 1'b0;
      pend[d] = 1'b0; due[d] = 0; acc_cnt[d] = 0;
    end
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b1; rst[1] = 1'b1;

    fork
      begin : p0
        logic [31:0] rd;
        logic        er;
        int          lat;
        for (int i = 0; i < D0; i++) txn(0, 1'b1, 32'(i * 4), pre(i), 4'hF, 0, rd, er, lat);
        // store then load
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("st10_lat", 32'(lat), 32'd3); chk("st10_rdata", rd, 32'd0); chk("st10_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("ld10_lat", 32'(lat), 32'd3); chk("ld10_rdata", rd, 32'hDEADBEEF); chk("ld10_err", 32'(er), 32'd0);
        // byte-enable merge
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("ld20_merge", rd, 32'h11BB33DD);
        // error cases
        txn(0, 1'b0, 32'h22, 32'h0, 4'hF, 0, rd, er, lat);
        chk("ld22_err", 32'(er), 32'd1); chk("ld22_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'(4 * D0), 32'h0, 4'hF, 0, rd, er, lat);
        chk("ldoor_err", 32'(er), 32'd1); chk("ldoor_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h400, 32'hDEADDEAD, 4'hF, 0, rd, er, lat);
        chk("st400_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
        chk("ld0_unchanged", rd, 32'hC0DE0000);
        // empty byte enables
        txn(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
        chk("stbe0_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
        chk("ld8_unchanged", rd, 32'hC0DE0002);
        // response held under backpressure
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("hold_rdata", rd, 32'hDEADBEEF);
        // reset during WAIT drops the store
        issue(0, 1'b1, 32'h30, 32'h55, 4'hF);
        rst[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst[0] = 1'b1;
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rstwait_ld30", rd, 32'hC0DE000C); chk("rstwait_lat", 32'(lat), 32'd3);
        // reset during RESP keeps the committed store
        issue(0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF);
        await_resp(0, lat, rd, er);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        #1 chk("async_drop", 32'(resp_valid[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst[0] = 1'b1;
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rstresp_ld40", rd, 32'h0BADF00D);
        rand_phase(0, 100, 3);
      end
      begin : p1
        logic [31:0] rd;
        logic        er;
        int          lat, n;
        for (int i = 0; i < D1; i++) txn(1, 1'b1, 32'(i * 4), pre(i), 4'hF, 0, rd, er, lat);
        txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
        chk("w0_lat", 32'(lat), 32'd1); chk("w0_rdata", rd, 32'hC0DE0001);
        txn(1, 1'b0, 32'(4 * D1), 32'h0, 4'h0, 0, rd, er, lat);
        chk("w0_oor_err", 32'(er), 32'd1);
        // back-to-back with both handshakes held high
        req_we[1] = 1'b0; req_addr[1] = 32'h4; req_valid[1] = 1'b1; resp_ready[1] = 1'b1;
        n = 0;
        repeat (10) begin
          @(negedge clk); if (req_ready[1]) n++;
          @(posedge clk);
        end
        #1;
        chk("b2b_accepts", 32'(n), 32'd5);
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        rand_phase(1, 100, 2);
      end
    join

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra cycles between request accept and response, legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load data (0 for stores and errors).
REQ-014 SHALL have port resp_err  output  1  access error flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid & req_ready; it latches we, addr, wdata, be in that edge.
REQ-018 On accept SHALL go to WAIT with countdown loaded to WAIT_CYCLES-1 when WAIT_CYCLES>0, else directly to RESP.
REQ-019 In WAIT SHALL decrement each cycle and go to RESP on the edge where the count is 0.
REQ-020 Latency: resp_valid SHALL first be high exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 On the edge entering RESP SHALL commit the store (enabled bytes only) and capture load data into resp_rdata.
REQ-022 In RESP SHALL hold resp_valid, resp_rdata, resp_err stable until resp_ready is high on a rising edge, then go to IDLE.
REQ-023 SHALL NOT accept a new request in the response-handshake cycle; minimum spacing between accepts is WAIT_CYCLES+2 cycles.
REQ-024 Error when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS: resp_err = 1, resp_rdata = 0, no memory write.
REQ-025 Store with req_be = 0 SHALL complete with resp_err = 0 and no memory change.
REQ-026 Loads SHALL ignore req_be and return the full word at req_addr[31:2].
REQ-027 Store response SHALL carry resp_rdata = 0.
REQ-028 A load following a store to the same word SHALL return the stored data (no stale read).
REQ-029 Changes on req_* inputs outside the accept edge SHALL have no effect.

Reset
REQ-030 While rst = 0: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, countdown = 0.
REQ-031 Reset asserted in WAIT SHALL abandon the transaction; the pending store SHALL NOT be committed.
REQ-032 Reset asserted in RESP SHALL drop resp_valid immediately (asynchronous), with no further effect on an already committed store.
REQ-033 Memory array contents SHALL NOT be cleared by reset.
REQ-034 After rst deasserts, the first request SHALL be accepted on the first rising edge with req_valid = 1.

Verification
REQ-035 Store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10, WAIT_CYCLES = 2 -> resp_valid 3 cycles after each accept; load resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-036 Store 0x11223344 to 0x20, then store 0xAABBCCDD with be 0x5, then load 0x20 -> 0x11BB33DD.
REQ-037 Load addr 0x22 (misaligned) and load addr 4*DEPTH_WORDS -> resp_err = 1, resp_rdata = 0; store to 0x400 with DEPTH_WORDS = 256 -> resp_err = 1, memory unchanged.
REQ-038 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid/rdata/err stable, req_ready = 0 throughout; accept completes on the first edge with resp_ready = 1.
REQ-039 Store 0x55 to 0x30, assert rst during WAIT, release, load 0x30 -> returns prior contents, not 0x55; resp_valid = 0 during reset.
REQ-040 WAIT_CYCLES = 0 back-to-back loads with req_valid and resp_ready held high -> resp_valid 1 cycle after accept, one accept every 2 cycles.
